// File: rtl/fu_completion_monitor.sv
// Execute-stage completion monitor: tracks one in-flight instruction per FU channel
// and reports protocol violations on issue/CDB/branch-resolve traffic.
module fu_completion_monitor #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned N       = 2,
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned BM_W    = 4,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       issue_valid,
  input  logic [NUM_CH*TAG_W-1:0] issue_tag,
  input  logic [NUM_CH*BM_W-1:0]  issue_bmask,
  input  logic [N-1:0]            cdb_valid,
  input  logic [N*TAG_W-1:0]      cdb_tag,
  input  logic [N*CH_W-1:0]       cdb_src,
  input  logic [BM_W-1:0]         resolve_mask,
  input  logic                    resolve_mispred,
  output logic                    err_valid,
  output logic [2:0]              err_code,
  output logic [CH_W-1:0]         err_ch,
  output logic [2:0]              err_sticky,
  output logic [7:0]              err_count,
  output logic [CNT_W-1:0]        inflight_count
);

  localparam int unsigned AGE_W  = $clog2(MAX_LAT + 1);
  localparam int unsigned HIT_W  = $clog2(N + 1);
  localparam int unsigned NCODE  = 5;
  localparam int unsigned SUM_W  = $clog2(NUM_CH * NCODE + 1);
  localparam int unsigned ACC_W  = 9 + SUM_W;

  // Violation vector bit b corresponds to error code b+1.
  localparam int unsigned V_DUP      = 0;
  localparam int unsigned V_SPUR     = 1;
  localparam int unsigned V_MISMATCH = 2;
  localparam int unsigned V_ISSBUSY  = 3;
  localparam int unsigned V_TIMEOUT  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_t;

  typedef struct packed {
    ch_state_t        st;
    logic [TAG_W-1:0] tag;
    logic [BM_W-1:0]  bmask;
    logic [AGE_W-1:0] age;
  } ch_entry_t;

  ch_entry_t [NUM_CH-1:0]            ch_q;
  ch_entry_t [NUM_CH-1:0]            ch_d;
  logic      [NUM_CH-1:0][NCODE-1:0] viol;

  logic             resolve_ok;
  logic             resolve_bad;
  logic [HIT_W-1:0] hits;
  logic             match;
  logic             any_hit;
  logic             busy;
  logic             squash;
  logic             timeout;
  logic [BM_W-1:0]  iss_bm;

  logic             rep_valid;
  logic [2:0]       rep_code;
  logic [CH_W-1:0]  rep_ch;
  logic [SUM_W-1:0] viol_sum;
  logic [ACC_W-1:0] count_acc;
  logic [7:0]       count_d;
  logic [CNT_W-1:0] inflight_d;

  // Per-channel next state and violation detection
  always_comb begin
    ch_d        = ch_q;
    viol        = '0;
    hits        = '0;
    match       = 1'b0;
    any_hit     = 1'b0;
    busy        = 1'b0;
    squash      = 1'b0;
    timeout     = 1'b0;
    iss_bm      = '0;
    resolve_ok  = (resolve_mask != '0) && !resolve_mispred;
    resolve_bad = (resolve_mask != '0) && resolve_mispred;

    for (int c = 0; c < NUM_CH; c++) begin
      hits  = '0;
      match = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (cdb_valid[k] && (cdb_src[k*CH_W +: CH_W] == CH_W'(c))) begin
          hits = hits + HIT_W'(1);
          if (cdb_tag[k*TAG_W +: TAG_W] == ch_q[c].tag) match = 1'b1;
        end
      end
      any_hit = (hits != '0);
      busy    = (ch_q[c].st == BUSY);
      squash  = busy && resolve_bad && ((ch_q[c].bmask & resolve_mask) != '0);
      timeout = busy && !any_hit && !squash &&
                ((32'(ch_q[c].age) + 32'd1) == MAX_LAT);

      if (hits > HIT_W'(1))       viol[c][V_DUP]      = 1'b1;
      else if (any_hit && !busy)  viol[c][V_SPUR]     = 1'b1;
      else if (any_hit && !match) viol[c][V_MISMATCH] = 1'b1;
      viol[c][V_TIMEOUT] = timeout;

      // Any CDB hit, a squash or a timeout retires the held instruction
      if (busy) begin
        if (any_hit || squash || timeout) begin
          ch_d[c] = '0;
        end else begin
          ch_d[c].age = ch_q[c].age + AGE_W'(1);
          if (resolve_ok) ch_d[c].bmask = ch_q[c].bmask & ~resolve_mask;
        end
      end

      // Issues on the wrong path of a same-cycle mispredict never enter the unit
      iss_bm = issue_bmask[c*BM_W +: BM_W];
      if (issue_valid[c] && !(resolve_bad && ((iss_bm & resolve_mask) != '0))) begin
        if (busy && !any_hit && !squash) viol[c][V_ISSBUSY] = 1'b1;
        ch_d[c].st    = BUSY;
        ch_d[c].tag   = issue_tag[c*TAG_W +: TAG_W];
        ch_d[c].bmask = resolve_ok ? (iss_bm & ~resolve_mask) : iss_bm;
        ch_d[c].age   = '0;
      end
    end
  end

  // Error arbitration (lowest channel, then lowest code) and counting
  always_comb begin
    rep_valid  = 1'b0;
    rep_code   = '0;
    rep_ch     = '0;
    viol_sum   = '0;
    inflight_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < NCODE; b++) viol_sum = viol_sum + SUM_W'(viol[c][b]);
      if (!rep_valid && (viol[c] != '0)) begin
        rep_valid = 1'b1;
        rep_ch    = CH_W'(c);
        for (int b = NCODE - 1; b >= 0; b--) begin
          if (viol[c][b]) rep_code = 3'(b + 1);
        end
      end
      inflight_d = inflight_d + CNT_W'(ch_d[c].st == BUSY);
    end
    count_acc = ACC_W'(err_count) + ACC_W'(viol_sum);
    count_d   = (count_acc > ACC_W'(255)) ? 8'hFF : count_acc[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ch_q           <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
      err_ch         <= '0;
      err_sticky     <= '0;
      err_count      <= '0;
      inflight_count <= '0;
    end else begin
      ch_q           <= ch_d;
      err_valid      <= rep_valid;
      err_code       <= rep_code;
      err_ch         <= rep_ch;
      err_count      <= count_d;
      inflight_count <= inflight_d;
      if (rep_valid && (err_sticky == '0)) err_sticky <= rep_code;
    end
  end

endmodule

// File: tb/tb_fu_completion_monitor.sv
// Directed bench for fu_completion_monitor with default parameters.
module tb_fu_completion_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  issue_valid;
  logic [23:0] issue_tag;
  logic [15:0] issue_bmask;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [3:0]  cdb_src;
  logic [3:0]  resolve_mask;
  logic        resolve_mispred;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [1:0]  err_ch;
  logic [2:0]  err_sticky;
  logic [7:0]  err_count;
  logic [2:0]  inflight_count;

  int errors = 0;
  int checks = 0;

  fu_completion_monitor dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_tag       (issue_tag),
    .issue_bmask     (issue_bmask),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_src         (cdb_src),
    .resolve_mask    (resolve_mask),
    .resolve_mispred (resolve_mispred),
    .err_valid       (err_valid),
    .err_code        (err_code),
    .err_ch          (err_ch),
    .err_sticky      (err_sticky),
    .err_count       (err_count),
    .inflight_count  (inflight_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid     = '0;
    issue_tag       = '0;
    issue_bmask     = '0;
    cdb_valid       = '0;
    cdb_tag         = '0;
    cdb_src         = '0;
    resolve_mask    = '0;
    resolve_mispred = 1'b0;
  endtask

  task automatic drive_issue(input int ch, input logic [5:0] tag, input logic [3:0] bm);
    issue_valid[ch]       = 1'b1;
    issue_tag[ch*6 +: 6]  = tag;
    issue_bmask[ch*4 +: 4] = bm;
  endtask

  task automatic drive_cdb(input int k, input logic [1:0] src, input logic [5:0] tag);
    cdb_valid[k]       = 1'b1;
    cdb_src[k*2 +: 2]  = src;
    cdb_tag[k*6 +: 6]  = tag;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got=%0d exp=0", err_valid); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    checks++; if (err_ch !== 2'd0) begin errors++; $display("FAIL reset_err_ch got=%0d exp=0", err_ch); end
    checks++; if (err_sticky !== 3'd0) begin errors++; $display("FAIL reset_err_sticky got=%0d exp=0", err_sticky); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_complete();
    clear_inputs();
    drive_issue(1, 6'h12, 4'b0000);
    tick();
    clear_inputs();
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL complete_inflight_busy got=%0d exp=1", inflight_count); end
    tick(); tick();
    drive_cdb(0, 2'd1, 6'h12);
    tick();
    clear_inputs();
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL complete_inflight_done got=%0d exp=0", inflight_count); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL complete_no_err got=%0d exp=0", err_valid); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL complete_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_timeout();
    clear_inputs();
    drive_issue(0, 6'h05, 4'b0000);
    tick();
    clear_inputs();
    for (int i = 1; i < 8; i++) tick();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL timeout_still_busy got=%0d exp=1", inflight_count); end
    tick();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got=%0d exp=1", err_valid); end
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL timeout_code got=%0d exp=5", err_code); end
    checks++; if (err_ch !== 2'd0) begin errors++; $display("FAIL timeout_ch got=%0d exp=0", err_ch); end
    checks++; if (err_sticky !== 3'd5) begin errors++; $display("FAIL timeout_sticky got=%0d exp=5", err_sticky); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", err_count); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL timeout_inflight got=%0d exp=0", inflight_count); end
    tick();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL timeout_one_pulse got=%0d exp=0", err_valid); end
  endtask

  task automatic test_latency_boundary();
    clear_inputs();
    drive_issue(1, 6'h21, 4'b0000);
    tick();
    clear_inputs();
    for (int i = 1; i < 8; i++) tick();
    drive_cdb(1, 2'd1, 6'h21);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL boundary_no_err got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL boundary_inflight got=%0d exp=0", inflight_count); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL boundary_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_spurious_issue_busy();
    clear_inputs();
    drive_issue(1, 6'h05, 4'b0000);
    tick();
    clear_inputs();
    drive_cdb(0, 2'd2, 6'h01);
    drive_issue(1, 6'h06, 4'b0000);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got=%0d exp=1", err_valid); end
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL multi_code got=%0d exp=4", err_code); end
    checks++; if (err_ch !== 2'd1) begin errors++; $display("FAIL multi_ch got=%0d exp=1", err_ch); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL multi_count got=%0d exp=3", err_count); end
    checks++; if (err_sticky !== 3'd5) begin errors++; $display("FAIL multi_sticky_hold got=%0d exp=5", err_sticky); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL multi_inflight got=%0d exp=1", inflight_count); end
    drive_cdb(0, 2'd1, 6'h06);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL replaced_tag_complete got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL replaced_inflight got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_mispredict();
    clear_inputs();
    drive_issue(3, 6'h07, 4'b0010);
    tick();
    clear_inputs();
    resolve_mask = 4'b0010; resolve_mispred = 1'b1;
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL squash_no_err got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL squash_inflight got=%0d exp=0", inflight_count); end
    drive_cdb(0, 2'd3, 6'h07);
    tick();
    clear_inputs();
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL squash_spurious_code got=%0d exp=2", err_code); end
    checks++; if (err_ch !== 2'd3) begin errors++; $display("FAIL squash_spurious_ch got=%0d exp=3", err_ch); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL squash_count got=%0d exp=4", err_count); end
  endtask

  task automatic test_correct_resolve();
    clear_inputs();
    drive_issue(0, 6'h09, 4'b0011);
    tick();
    clear_inputs();
    resolve_mask = 4'b0001;
    tick();
    clear_inputs();
    resolve_mask = 4'b0001; resolve_mispred = 1'b1;
    tick();
    clear_inputs();
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL resolve_keeps_busy got=%0d exp=1", inflight_count); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL resolve_no_err got=%0d exp=0", err_valid); end
    drive_cdb(1, 2'd0, 6'h09);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL resolve_complete got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL resolve_inflight got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_squash_same_cycle();
    clear_inputs();
    drive_issue(2, 6'h03, 4'b0100);
    tick();
    clear_inputs();
    resolve_mask = 4'b0100; resolve_mispred = 1'b1;
    drive_cdb(0, 2'd2, 6'h03);
    drive_issue(1, 6'h0A, 4'b0100);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL squash_cdb_no_err got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL squash_drop_issue got=%0d exp=0", inflight_count); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL squash_same_count got=%0d exp=4", err_count); end
  endtask

  task automatic test_tag_mismatch();
    clear_inputs();
    drive_issue(2, 6'h10, 4'b0000);
    tick();
    clear_inputs();
    drive_cdb(1, 2'd2, 6'h11);
    tick();
    clear_inputs();
    checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL mismatch_code got=%0d exp=3", err_code); end
    checks++; if (err_ch !== 2'd2) begin errors++; $display("FAIL mismatch_ch got=%0d exp=2", err_ch); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL mismatch_count got=%0d exp=5", err_count); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL mismatch_inflight got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    drive_issue(0, 6'h01, 4'b0000);
    tick();
    clear_inputs();
    drive_cdb(0, 2'd0, 6'h01);
    drive_issue(0, 6'h02, 4'b0000);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_err got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL b2b_inflight got=%0d exp=1", inflight_count); end
    drive_cdb(0, 2'd0, 6'h02);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_no_err got=%0d exp=0", err_valid); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL b2b_done got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_dup_reset();
    clear_inputs();
    drive_issue(0, 6'h04, 4'b0000);
    tick();
    clear_inputs();
    drive_cdb(0, 2'd0, 6'h04);
    drive_cdb(1, 2'd0, 6'h04);
    tick();
    clear_inputs();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL dup_valid got=%0d exp=1", err_valid); end
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL dup_code got=%0d exp=1", err_code); end
    checks++; if (err_count !== 8'd6) begin errors++; $display("FAIL dup_count got=%0d exp=6", err_count); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL dup_inflight got=%0d exp=0", inflight_count); end
    reset = 1'b1;
    drive_issue(2, 6'h15, 4'b0000);
    drive_cdb(0, 2'd3, 6'h00);
    tick();
    reset = 1'b0;
    clear_inputs();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_err_valid got=%0d exp=0", err_valid); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_err_code got=%0d exp=0", err_code); end
    checks++; if (err_sticky !== 3'd0) begin errors++; $display("FAIL rst_err_sticky got=%0d exp=0", err_sticky); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL rst_inflight got=%0d exp=0", inflight_count); end
    tick();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_after_quiet got=%0d exp=0", err_valid); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_complete();
    test_timeout();
    test_latency_boundary();
    test_spurious_issue_busy();
    test_mispredict();
    test_correct_resolve();
    test_squash_same_cycle();
    test_tag_mismatch();
    test_back_to_back();
    test_dup_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_completion_monitor.md
# fu_completion_monitor

Synthesizable, parametrised execute-stage completion monitor. It tracks every instruction issued to each functional-unit channel until that instruction broadcasts on the CDB or is squashed by a branch mispredict. It flags protocol violations (timeout, spurious or duplicate broadcast, tag mismatch, issue into a busy unit) as registered error outputs. It sits beside the execute stage, observes issue, CDB and branch-resolve traffic, and never drives the datapath.

## Interface
Parameters:
- NUM_CH, 4: number of monitored FU channels
- N, 2: CDB width (broadcasts per cycle)
- MAX_LAT, 8: maximum legal issue-to-CDB latency in cycles (≥1)
- TAG_W, 6: physical register tag width
- BM_W, 4: branch mask width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  NUM_CH  per-channel issue strobe
- issue_tag  in  NUM_CH×TAG_W  destination tag of the issuing instruction
- issue_bmask  in  NUM_CH×BM_W  branch mask of the issuing instruction
- cdb_valid  in  N  CDB entry valid
- cdb_tag  in  N×TAG_W  broadcast tag
- cdb_src  in  N×$clog2(NUM_CH)  index of the channel that owns each CDB entry
- resolve_mask  in  BM_W  one-hot mask of the branch resolving this cycle (zero = no resolve)
- resolve_mispred  in  1  resolving branch mispredicted
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  error code, valid with err_valid
- err_ch  out  $clog2(NUM_CH)  offending channel, valid with err_valid
- err_sticky  out  3  first error code since reset (0 = none)
- err_count  out  8  saturating error count
- inflight_count  out  $clog2(NUM_CH+1)  channels currently BUSY

## Operation
- Per-channel FSM with states IDLE and BUSY. Each BUSY channel holds tag, bmask, and age (width $clog2(MAX_LAT+1)).
- IDLE + issue_valid: go to BUSY. Latch the tag, latch the bmask with the correctly-resolved bit removed, and set age=0.
- BUSY + issue_valid with no same-cycle completion on that channel: ISSUE_BUSY. The new instruction replaces the old one, and age is reset.
- BUSY + same-cycle completion + issue: legal back-to-back. The old instruction retires and the new one is latched.
- CDB entry k valid, src=c:
  - c BUSY and tag equal: completion, go to IDLE.
  - c BUSY and tag differs: TAG_MISMATCH, go to IDLE.
  - c IDLE: SPURIOUS.
- Two or more valid CDB entries with the same src in one cycle: DUP_GRANT. The channel goes to IDLE.
- BUSY with no completion: age increments each cycle. When age would reach MAX_LAT: TIMEOUT, go to IDLE.
- Branch resolve, correct prediction (resolve_mask≠0, resolve_mispred=0): clear the resolve_mask bit in every stored bmask.
- Branch resolve, mispredict: every BUSY channel with (bmask & resolve_mask)≠0 goes to IDLE with no error.
  - A same-cycle CDB completion from a squashed channel is still legal, and no error is raised.
  - A same-cycle issue whose issue_bmask intersects resolve_mask is dropped, and the channel stays IDLE.
- Error codes: 1 DUP_GRANT, 2 SPURIOUS, 3 TAG_MISMATCH, 4 ISSUE_BUSY, 5 TIMEOUT.
- Only one error is reported per cycle:
  - Lowest channel index wins.
  - Within a channel, the lowest code wins.
  - Other simultaneous errors increment err_count but are otherwise dropped.
- err_sticky latches the code of the first reported error and holds it until reset.
- err_count adds the number of distinct (channel, code) violations each cycle and saturates at 255.

## Timing
- All outputs are registered. An event sampled at rising edge T appears on err_* and inflight_count after edge T (visible in cycle T+1).
- err_valid is high for exactly one cycle per reporting cycle. Consecutive-cycle errors produce consecutive pulses.
- Issue sampled at edge t: a completion sampled at edges t+1 … t+MAX_LAT is legal. With no completion, TIMEOUT is recorded at edge t+MAX_LAT.
- inflight_count equals the number of BUSY channels after the current edge's updates.
- Reset values: all channels IDLE, age=0, err_valid=0, err_code=0, err_ch=0, err_sticky=0, err_count=0, inflight_count=0.
- Reset asserted mid-operation: all state is cleared at that edge, inputs in that cycle are ignored, and no error is reported.

## Test plan
- Issue tag 0x12 on ch1 at cycle 0, CDB {src=1, tag=0x12} at cycle 3 -> no error; inflight_count goes 1 then 0 after edge 3.
- Issue on ch0 with MAX_LAT=8 and no CDB -> err_valid pulse with code 5 and err_ch=0 after edge 8; err_sticky=5.
- CDB {src=2} while ch2 is IDLE, plus the same cycle an issue on ch1 while BUSY -> code 4 reported with err_ch=1; err_count increases by 2.
- Ch3 BUSY with bmask 0b0010, resolve_mask 0b0010 with mispred -> ch3 goes IDLE with no error; a later CDB {src=3} -> SPURIOUS (code 2).
- Correct resolve of 0b0001 while ch0 holds bmask 0b0011, then mispredict of 0b0001 -> ch0 stays BUSY; ch0 later completes with no error.
- Two CDB entries with src=0 in one cycle, with reset asserted in the next cycle -> code 1 pulse, then all outputs return to 0.
